// File: rtl/raster_pkg.sv
// Shared raster definitions for the bounding-box scanner and the shading stage.
//
// Contents:
//   H_RES_DEFAULT / V_RES_DEFAULT : default screen size in pixels
//   COORD_W / PIX_W               : vertex coordinate width and pixel counter width
//   VX_LSB / VY_LSB / VZ_LSB      : bit positions of x, y, z inside a 36-bit vertex
//   scan_state_t                  : scanner FSM state encoding
//   vertex_x/y/z                  : field extraction helpers
package raster_pkg;

   localparam int H_RES_DEFAULT = 640;
   localparam int V_RES_DEFAULT = 480;

   localparam int COORD_W  = 10;
   localparam int PIX_W    = 11;
   localparam int DEPTH_W  = 16;
   localparam int VERTEX_W = 36;

   localparam int VX_LSB = 26;
   localparam int VY_LSB = 16;
   localparam int VZ_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   function automatic logic [COORD_W-1:0] vertex_x(input logic [VERTEX_W-1:0] v);
      return v[VX_LSB +: COORD_W];
   endfunction

   function automatic logic [COORD_W-1:0] vertex_y(input logic [VERTEX_W-1:0] v);
      return v[VY_LSB +: COORD_W];
   endfunction

   function automatic logic [DEPTH_W-1:0] vertex_z(input logic [VERTEX_W-1:0] v);
      return v[VZ_LSB +: DEPTH_W];
   endfunction

endpackage

// File: rtl/min_max3.sv
// Combinational unsigned minimum and maximum of three coordinate values.
//
// Ports:
//   a, b, c  in  COORD_W  candidate values
//   min_val  out COORD_W  smallest of a, b, c
//   max_val  out COORD_W  largest of a, b, c
module min_max3
   import raster_pkg::*;
(
   input  logic [COORD_W-1:0] a,
   input  logic [COORD_W-1:0] b,
   input  logic [COORD_W-1:0] c,
   output logic [COORD_W-1:0] min_val,
   output logic [COORD_W-1:0] max_val
);

   logic [COORD_W-1:0] ab_min;
   logic [COORD_W-1:0] ab_max;

   // Reduce a/b first, then fold c into both extremes.
   always_comb begin
      ab_min  = (a < b) ? a : b;
      ab_max  = (a < b) ? b : a;
      min_val = (c < ab_min) ? c : ab_min;
      max_val = (c > ab_max) ? c : ab_max;
   end

endmodule

// File: rtl/tri_bbox_scan.sv
// Triangle bounding-box scanner: latches a projected triangle, computes its
// screen-space bounding box and walks every pixel of that box in row-major
// order, handing each one to the shading stage over a valid/ready handshake.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   start            one-cycle request to scan proj_vertex_in (honoured in IDLE only)
//   proj_vertex_in   three vertices, x=[35:26] y=[25:16] z=[15:0]
//   set_in           face/colour-set index travelling with the triangle
//   busy             high while a triangle is being processed
//   proj_vertex_out  latched triangle, stable for the whole scan
//   set_out          latched set index
//   x, y             current pixel coordinate
//   pix_valid        x/y carry a pixel for the shading stage
//   pix_ready        shading stage accepts the pixel
//   done             one-cycle pulse when the triangle is finished
//
// Build option TRI_BBOX_SCAN_CLIP_EN: when defined, the box is clamped to the
// screen and boxes lying entirely off-screen produce no pixels. When undefined,
// any vertex beyond H_RES/V_RES rejects the whole triangle.
module tri_bbox_scan
   import raster_pkg::*;
#(
   parameter int H_RES = H_RES_DEFAULT,
   parameter int V_RES = V_RES_DEFAULT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [2:0][VERTEX_W-1:0]     proj_vertex_in,
   input  logic [1:0]                   set_in,
   output logic                         busy,
   output logic [2:0][VERTEX_W-1:0]     proj_vertex_out,
   output logic [1:0]                   set_out,
   output logic [PIX_W-1:0]             x,
   output logic [PIX_W-1:0]             y,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   output logic                         done
);

   scan_state_t state;
   scan_state_t state_next;

   logic [COORD_W-1:0] box_x_min;
   logic [COORD_W-1:0] box_x_max;
   logic [COORD_W-1:0] box_y_min;
   logic [COORD_W-1:0] box_y_max;

   logic [PIX_W-1:0] lim_x_max;
   logic [PIX_W-1:0] lim_y_max;
   logic             box_empty;

   logic [PIX_W-1:0] x_min_q;
   logic [PIX_W-1:0] x_max_q;
   logic [PIX_W-1:0] y_max_q;

   logic handshake;
   logic last_x;
   logic last_y;

   // The box is derived from the latched triangle so that a new proj_vertex_in
   // arriving during SETUP cannot disturb the scan.
   min_max3 u_x_range (
      .a       (vertex_x(proj_vertex_out[0])),
      .b       (vertex_x(proj_vertex_out[1])),
      .c       (vertex_x(proj_vertex_out[2])),
      .min_val (box_x_min),
      .max_val (box_x_max)
   );

   min_max3 u_y_range (
      .a       (vertex_y(proj_vertex_out[0])),
      .b       (vertex_y(proj_vertex_out[1])),
      .c       (vertex_y(proj_vertex_out[2])),
      .min_val (box_y_min),
      .max_val (box_y_max)
   );

`ifdef TRI_BBOX_SCAN_CLIP_EN
   localparam logic [PIX_W-1:0] X_LAST = PIX_W'(H_RES - 1);
   localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(V_RES - 1);

   // Clamp the far edges to the last on-screen pixel; a box whose near edge is
   // already off-screen has nothing visible and is skipped.
   always_comb begin
      box_empty = ({1'b0, box_x_min} > X_LAST) || ({1'b0, box_y_min} > Y_LAST);
      lim_x_max = ({1'b0, box_x_max} > X_LAST) ? X_LAST : {1'b0, box_x_max};
      lim_y_max = ({1'b0, box_y_max} > Y_LAST) ? Y_LAST : {1'b0, box_y_max};
   end
`else
   localparam logic [PIX_W-1:0] X_LIMIT = PIX_W'(H_RES);
   localparam logic [PIX_W-1:0] Y_LIMIT = PIX_W'(V_RES);

   // Without clipping, a triangle reaching beyond the screen limit is dropped
   // whole; the largest vertex coordinate decides that for all three.
   always_comb begin
      box_empty = ({1'b0, box_x_max} > X_LIMIT) || ({1'b0, box_y_max} > Y_LIMIT);
      lim_x_max = {1'b0, box_x_max};
      lim_y_max = {1'b0, box_y_max};
   end
`endif

   assign handshake = pix_valid && pix_ready;
   assign last_x    = (x == x_max_q);
   assign last_y    = (y == y_max_q);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs, all decoded straight from the state register.
   always_comb begin
      state_next = state;
      busy       = (state != ST_IDLE);
      pix_valid  = (state == ST_SCAN);
      done       = (state == ST_DONE);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next = box_empty ? ST_DONE : ST_SCAN;
         end
         ST_SCAN: begin
            if (handshake && last_x && last_y) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Triangle latch, box bounds and the row-major pixel walker. x/y only move
   // on an accepted pixel, so stalls simply hold the current coordinate.
   always_ff @(posedge clk) begin
      if (reset) begin
         proj_vertex_out <= '0;
         set_out         <= '0;
         x               <= '0;
         y               <= '0;
         x_min_q         <= '0;
         x_max_q         <= '0;
         y_max_q         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  proj_vertex_out <= proj_vertex_in;
                  set_out         <= set_in;
               end
            end
            ST_SETUP: begin
               x       <= {1'b0, box_x_min};
               y       <= {1'b0, box_y_min};
               x_min_q <= {1'b0, box_x_min};
               x_max_q <= lim_x_max;
               y_max_q <= lim_y_max;
            end
            ST_SCAN: begin
               if (handshake) begin
                  if (!last_x) begin
                     x <= x + PIX_W'(1);
                  end else if (!last_y) begin
                     x <= x_min_q;
                     y <= y + PIX_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_bbox_scan.sv
// Directed self-checking bench for tri_bbox_scan.
module tb_tri_bbox_scan;

   logic                clk;
   logic                reset;
   logic                start;
   logic [2:0][35:0]    proj_vertex_in;
   logic [1:0]          set_in;
   logic                busy;
   logic [2:0][35:0]    proj_vertex_out;
   logic [1:0]          set_out;
   logic [10:0]         x;
   logic [10:0]         y;
   logic                pix_valid;
   logic                pix_ready;
   logic                done;

   int n_compared;
   int n_mismatched;

   int obs_x[$];
   int obs_y[$];
   int exp_x[$];
   int exp_y[$];

   tri_bbox_scan dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .proj_vertex_in  (proj_vertex_in),
      .set_in          (set_in),
      .busy            (busy),
      .proj_vertex_out (proj_vertex_out),
      .set_out         (set_out),
      .x               (x),
      .y               (y),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0][35:0] mk_tri(input int x0, input int y0, input int x1,
                                               input int y1, input int x2, input int y2);
      logic [2:0][35:0] t;
      t[0] = {10'(x0), 10'(y0), 16'h0180};
      t[1] = {10'(x1), 10'(y1), 16'h0240};
      t[2] = {10'(x2), 10'(y2), 16'h0300};
      return t;
   endfunction

   // Row-major list of every pixel in a hand-computed box.
   task automatic build_box(input int x0, input int x1, input int y0, input int y1);
      exp_x.delete();
      exp_y.delete();
      for (int yy = y0; yy <= y1; yy++) begin
         for (int xx = x0; xx <= x1; xx++) begin
            exp_x.push_back(xx);
            exp_y.push_back(yy);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      start     = 1'b0;
      pix_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives one triangle (start in cycle 1) and records accepted pixels.
   // stall_mode 1 drops pix_ready on every even cycle. extra_start re-pulses
   // start with a different triangle in that cycle. done_cycle stays -1 when
   // the budget runs out.
   task automatic run_scan(input logic [2:0][35:0] tri_v, input logic [1:0] set_v,
                           input int stall_mode, input int extra_start, input int budget,
                           output int first_valid, output int done_cycle,
                           output int hold_breaks, output logic done_after,
                           output logic busy_after);
      int          cyc;
      logic        prev_stalled;
      logic [10:0] prev_x;
      logic [10:0] prev_y;
      obs_x.delete();
      obs_y.delete();
      first_valid  = -1;
      done_cycle   = -1;
      hold_breaks  = 0;
      done_after   = 1'bx;
      busy_after   = 1'bx;
      prev_stalled = 1'b0;
      prev_x       = '0;
      prev_y       = '0;
      for (cyc = 1; cyc <= budget; cyc++) begin
         if (done === 1'b1) begin
            done_cycle = cyc;
            break;
         end
         start          = (cyc == 1) || (cyc == extra_start);
         proj_vertex_in = (cyc == 1) ? tri_v : mk_tri(100, 100, 101, 100, 100, 101);
         set_in         = (cyc == 1) ? set_v : ~set_v;
         pix_ready      = (stall_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
         if (pix_valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            if (prev_stalled && (x !== prev_x || y !== prev_y)) hold_breaks++;
            if (pix_ready) begin
               obs_x.push_back(int'(x));
               obs_y.push_back(int'(y));
            end
         end
         prev_stalled = (pix_valid === 1'b1) && !pix_ready;
         prev_x       = x;
         prev_y       = y;
         @(negedge clk);
      end
      start     = 1'b0;
      pix_ready = 1'b0;
      if (done_cycle >= 0) begin
         @(negedge clk);
         done_after = done;
         busy_after = busy;
      end
   endtask

   task automatic test_basic();
      int fv, dc, hb;
      logic da, ba;
      logic [2:0][35:0] t;
      t = mk_tri(10, 20, 12, 20, 10, 21);
      do_reset();
      build_box(10, 12, 20, 21);
      run_scan(t, 2'b10, 0, 0, 60, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== 6) begin
         n_mismatched++;
         $display("[TB] FAIL basic_count: got %0d expected 6", obs_x.size());
      end
      for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
         n_compared++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            n_mismatched++;
            $display("[TB] FAIL basic_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                     i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_compared++;
      if (fv !== 3) begin
         n_mismatched++;
         $display("[TB] FAIL basic_first_valid: got cycle %0d expected 3", fv);
      end
      n_compared++;
      if (dc !== 9) begin
         n_mismatched++;
         $display("[TB] FAIL basic_done_cycle: got %0d expected 9", dc);
      end
      n_compared++;
      if (da !== 1'b0 || ba !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL basic_after_done: got done=%b busy=%b expected 0 0", da, ba);
      end
      n_compared++;
      if (set_out !== 2'b10 || proj_vertex_out !== t) begin
         n_mismatched++;
         $display("[TB] FAIL basic_latch: got set=%b tri=%h expected set=10 tri=%h",
                  set_out, proj_vertex_out, t);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_compared++;
      if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_flags: got busy=%b valid=%b done=%b expected 0 0 0",
                  busy, pix_valid, done);
      end
      n_compared++;
      if (x !== 11'd0 || y !== 11'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_xy: got (%0d,%0d) expected (0,0)", x, y);
      end
      n_compared++;
      if (set_out !== 2'b00 || proj_vertex_out !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_latch: got set=%b tri=%h expected zero", set_out, proj_vertex_out);
      end
   endtask

   task automatic test_stall();
      int fv, dc, hb;
      logic da, ba;
      do_reset();
      build_box(10, 12, 20, 21);
      run_scan(mk_tri(10, 20, 12, 20, 10, 21), 2'b01, 1, 0, 80, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== 6) begin
         n_mismatched++;
         $display("[TB] FAIL stall_count: got %0d expected 6", obs_x.size());
      end
      for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
         n_compared++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            n_mismatched++;
            $display("[TB] FAIL stall_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                     i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_compared++;
      if (hb !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL stall_hold: got %0d moves during stall expected 0", hb);
      end
      n_compared++;
      if (dc !== 14) begin
         n_mismatched++;
         $display("[TB] FAIL stall_done_cycle: got %0d expected 14", dc);
      end
   endtask

   task automatic test_single_point();
      int fv, dc, hb;
      logic da, ba;
      do_reset();
      run_scan(mk_tri(5, 5, 5, 5, 5, 5), 2'b11, 0, 0, 40, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL point_count: got %0d expected 1", obs_x.size());
      end else begin
         n_compared++;
         if (obs_x[0] !== 5 || obs_y[0] !== 5) begin
            n_mismatched++;
            $display("[TB] FAIL point_pixel: got (%0d,%0d) expected (5,5)", obs_x[0], obs_y[0]);
         end
      end
      n_compared++;
      if (dc !== 4) begin
         n_mismatched++;
         $display("[TB] FAIL point_done_cycle: got %0d expected 4", dc);
      end
   endtask

   task automatic test_screen_edge();
      int fv, dc, hb, exp_dc;
      logic da, ba;
      // Box straddling the right and bottom edges of a 640x480 screen.
      do_reset();
`ifdef TRI_BBOX_SCAN_CLIP_EN
      build_box(630, 639, 470, 479);
      exp_dc = 103;
`else
      exp_x.delete();
      exp_y.delete();
      exp_dc = 3;
`endif
      run_scan(mk_tri(630, 470, 700, 470, 630, 500), 2'b00, 0, 0, 300, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== exp_x.size()) begin
         n_mismatched++;
         $display("[TB] FAIL edge_count: got %0d expected %0d", obs_x.size(), exp_x.size());
      end
      for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
         n_compared++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            n_mismatched++;
            $display("[TB] FAIL edge_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                     i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_compared++;
      if (dc !== exp_dc) begin
         n_mismatched++;
         $display("[TB] FAIL edge_done_cycle: got %0d expected %0d", dc, exp_dc);
      end
      // A vertex exactly at x=H_RES is accepted unclipped, clamped when clipping.
      do_reset();
`ifdef TRI_BBOX_SCAN_CLIP_EN
      build_box(638, 639, 0, 1);
      exp_dc = 7;
`else
      build_box(638, 640, 0, 1);
      exp_dc = 9;
`endif
      run_scan(mk_tri(638, 0, 640, 0, 638, 1), 2'b00, 0, 0, 60, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== exp_x.size()) begin
         n_mismatched++;
         $display("[TB] FAIL limit_count: got %0d expected %0d", obs_x.size(), exp_x.size());
      end
      for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
         n_compared++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            n_mismatched++;
            $display("[TB] FAIL limit_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                     i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_compared++;
      if (dc !== exp_dc) begin
         n_mismatched++;
         $display("[TB] FAIL limit_done_cycle: got %0d expected %0d", dc, exp_dc);
      end
   endtask

   task automatic test_reset_mid_scan();
      int fv, dc, hb, seen_done;
      logic da, ba;
      do_reset();
      proj_vertex_in = mk_tri(10, 20, 12, 20, 10, 21);
      set_in         = 2'b01;
      start          = 1'b1;
      pix_ready      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_compared++;
      if (pix_valid !== 1'b1 || x !== 11'd12 || y !== 11'd20) begin
         n_mismatched++;
         $display("[TB] FAIL midreset_third: got valid=%b (%0d,%0d) expected 1 (12,20)",
                  pix_valid, x, y);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_compared++;
      if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midreset_after: got valid=%b busy=%b done=%b expected 0 0 0",
                  pix_valid, busy, done);
      end
      pix_ready = 1'b0;
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0 || pix_valid !== 1'b0) seen_done++;
      end
      n_compared++;
      if (seen_done !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", seen_done);
      end
      build_box(10, 12, 20, 21);
      run_scan(mk_tri(10, 20, 12, 20, 10, 21), 2'b01, 0, 0, 60, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== 6 || dc !== 9) begin
         n_mismatched++;
         $display("[TB] FAIL midreset_rescan: got %0d pixels done %0d expected 6 pixels done 9",
                  obs_x.size(), dc);
      end
   endtask

   task automatic test_start_while_busy();
      int fv, dc, hb;
      logic da, ba;
      logic [2:0][35:0] t;
      int starts[2] = '{2, 5};
      t = mk_tri(10, 20, 12, 20, 10, 21);
      build_box(10, 12, 20, 21);
      for (int k = 0; k < 2; k++) begin
         do_reset();
         run_scan(t, 2'b10, 0, starts[k], 60, fv, dc, hb, da, ba);
         n_compared++;
         if (obs_x.size() !== 6) begin
            n_mismatched++;
            $display("[TB] FAIL busy_start%0d_count: got %0d expected 6", starts[k], obs_x.size());
         end
         for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
            n_compared++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
               n_mismatched++;
               $display("[TB] FAIL busy_start%0d_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                        starts[k], i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
            end
         end
         n_compared++;
         if (proj_vertex_out !== t || set_out !== 2'b10 || dc !== 9) begin
            n_mismatched++;
            $display("[TB] FAIL busy_start%0d_latch: got tri=%h set=%b done %0d expected tri=%h set=10 done 9",
                     starts[k], proj_vertex_out, set_out, dc, t);
         end
      end
   endtask

   task automatic test_back_to_back();
      int fv, dc, hb;
      logic da, ba;
      do_reset();
      run_scan(mk_tri(3, 7, 3, 7, 4, 7), 2'b00, 0, 0, 40, fv, dc, hb, da, ba);
      build_box(1, 2, 1, 3);
      run_scan(mk_tri(2, 1, 1, 3, 2, 2), 2'b11, 0, 0, 40, fv, dc, hb, da, ba);
      n_compared++;
      if (obs_x.size() !== 6 || fv !== 3 || dc !== 9) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_timing: got %0d pixels valid %0d done %0d expected 6 3 9",
                  obs_x.size(), fv, dc);
      end
      for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
         n_compared++;
         if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_pixel%0d: got (%0d,%0d) expected (%0d,%0d)",
                     i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
         end
      end
   endtask

   initial begin
      n_compared     = 0;
      n_mismatched   = 0;
      reset          = 1'b1;
      start          = 1'b0;
      pix_ready      = 1'b0;
      proj_vertex_in = '0;
      set_in         = '0;
      test_basic();
      test_reset();
      test_stall();
      test_single_point();
      test_screen_edge();
      test_reset_mid_scan();
      test_start_while_busy();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/tri_bbox_scan.md
TRI_BBOX_SCAN -- requirements
Module: tri_bbox_scan

Interface
REQ-001 SHALL have parameter H_RES, default 640, screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, screen height in pixels.
REQ-003 Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to scan the triangle on proj_vertex_in.
REQ-006 proj_vertex_in  in  [2:0][35:0]  per vertex: x=[35:26], y=[25:16], z=[15:0] (unsigned 8.8).
REQ-007 set_in  in  2  face/colour-set index accompanying the triangle.
REQ-008 busy  out  1  high from start acceptance until done.
REQ-009 proj_vertex_out  out  [2:0][35:0]  latched triangle, stable for the whole scan.
REQ-010 set_out  out  2  latched set_in.
REQ-011 x, y  out  11 each  current pixel coordinate.
REQ-012 pix_valid  out  1  x/y hold a pixel for the downstream shading stage.
REQ-013 pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
REQ-014 done  out  1  one-cycle pulse after the last pixel (or an empty triangle) completes.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> SCAN -> DONE -> IDLE.
REQ-016 IDLE: start=1 SHALL latch proj_vertex_in and set_in, assert busy, and go to SETUP; start SHALL be ignored in every other state.
REQ-017 SETUP (one cycle): SHALL compute xmin/xmax/ymin/ymax as the unsigned min/max of the three 10-bit x and y fields.
REQ-018 SETUP SHALL load x=xmin, y=ymin and go to SCAN; first pix_valid SHALL occur 2 cycles after the start cycle.
REQ-019 SCAN: pix_valid SHALL be 1; x, y SHALL hold until a handshake (valid && ready).
REQ-020 On handshake with x<xmax: x SHALL increment by 1.
REQ-021 On handshake with x==xmax and y<ymax: x SHALL reload xmin and y SHALL increment by 1 (row-major order).
REQ-022 On handshake with x==xmax and y==ymax: SHALL go to DONE and drop pix_valid next cycle.
REQ-023 DONE: done=1 for exactly one cycle, busy SHALL clear, next state IDLE.
REQ-024 Degenerate triangles (all vertices equal, collinear) SHALL still scan their bounding box; a single-point box SHALL emit exactly one pixel.
REQ-025 Pixel count per triangle SHALL be (xmax-xmin+1)*(ymax-ymin+1) after clipping; no pixel SHALL repeat or be skipped under arbitrary pix_ready stalls.
REQ-026 Inside/outside testing is not this block's job; every bounding-box pixel SHALL be emitted.

Reset
REQ-027 Reset SHALL force IDLE; busy, pix_valid, done, x, y, set_out = 0; proj_vertex_out = 0.
REQ-028 Reset asserted mid-scan SHALL abandon the triangle without a done pulse; pix_valid SHALL be 0 in the cycle after Reset.

Configuration
REQ-029 Macro TRI_BBOX_SCAN_CLIP_EN defined: SETUP SHALL clamp xmax to H_RES-1 and ymax to V_RES-1; if xmin>H_RES-1 or ymin>V_RES-1, SHALL go SETUP -> DONE with zero pixels.
REQ-030 Macro undefined: any vertex with x>H_RES or y>V_RES SHALL reject the triangle (SETUP -> DONE, zero pixels); otherwise the unclamped box SHALL be scanned.

Structure
REQ-031 H_RES/V_RES defaults, vertex field bit positions and the FSM state enum SHALL live in shared package raster_pkg, also used by the shading stage.
REQ-032 A sub-module min_max3 (combinational min and max of three 10-bit values) SHALL be instantiated twice (x and y).

Verification
REQ-033 Vertices (10,20),(12,20),(10,21), pix_ready=1 -> pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), first valid 2 cycles after start, done on cycle 9.
REQ-034 Same triangle, pix_ready toggling 1,0,1,0 -> identical 6-pixel sequence, each coordinate held through stalls.
REQ-035 All vertices (5,5) -> exactly one pixel (5,5) then done.
REQ-036 CLIP_EN defined, vertices (630,470),(700,470),(630,500) -> box x 630..639, y 470..479, 100 pixels; undefined -> zero pixels, done 2 cycles after start.
REQ-037 Reset pulsed during the 3rd pixel of REQ-033 -> pix_valid=0, busy=0 next cycle, no done; a new start then scans normally.
REQ-038 start pulsed while busy -> ignored; latched triangle and pixel sequence unchanged.
